// File: rtl/mux41_pkg.sv
// Shared constants and the select decode used by the 4:1 mux slice.
package mux41_pkg;

  localparam int LANES = 4;
  localparam int SEL_W = 2;

  function automatic logic [LANES-1:0] sel_to_onehot(input logic [SEL_W-1:0] s);
    logic [LANES-1:0] oh;
    oh    = '0;
    oh[s] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/mux41_dec.sv
// 2-to-4 one-hot decoder; every select code maps to exactly one set bit.
module mux41_dec
  import mux41_pkg::*;
(
  input  logic [SEL_W-1:0] sel,
  output logic [LANES-1:0] onehot
);

  always_comb begin
    onehot = sel_to_onehot(sel);
  end

endmodule

// File: rtl/mux41_d.sv
// 4:1 lane mux built as an AND-OR of one-hot gated lanes, with an
// optional output register selected at elaboration time.
module mux41_d
  import mux41_pkg::*;
#(
  parameter int DATA_W  = 1,
  parameter int REG_OUT = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [LANES*DATA_W-1:0] in,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    in_valid,
  output logic [DATA_W-1:0]       out,
  output logic                    out_valid,
  output logic [LANES-1:0]        sel_onehot
);

  logic [LANES-1:0]  onehot;
  logic [DATA_W-1:0] mux_data;

  mux41_dec u_dec (
    .sel    (sel),
    .onehot (onehot)
  );

  always_comb begin
    mux_data = '0;
    for (int k = 0; k < LANES; k++) begin
      mux_data = mux_data | (in[k*DATA_W +: DATA_W] & {DATA_W{onehot[k]}});
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg
      logic [DATA_W-1:0] out_q;
      logic [LANES-1:0]  oh_q;
      logic              valid_q;

      // Data and decode only load on qualified cycles; valid follows in_valid.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          out_q   <= '0;
          oh_q    <= '0;
          valid_q <= 1'b0;
        end else begin
          if (in_valid) begin
            out_q <= mux_data;
            oh_q  <= onehot;
          end
          valid_q <= in_valid;
        end
      end

      assign out        = out_q;
      assign sel_onehot = oh_q;
      assign out_valid  = valid_q;
    end else begin : g_comb
      logic unused_clk_rst;
      assign unused_clk_rst = clk ^ rst_n;

      assign out        = mux_data;
      assign sel_onehot = onehot;
      assign out_valid  = in_valid;
    end
  endgenerate

endmodule

// File: tb/tb_mux41_d.sv
// Directed bench for mux41_d: registered 1-bit, registered 8-bit and combinational builds.
module tb_mux41_d;

  logic clk;
  logic rst_n;

  logic [3:0]  in_n;
  logic [1:0]  sel_n;
  logic        valid_n;
  logic        out_n;
  logic        out_valid_n;
  logic [3:0]  oh_n;

  logic [31:0] in_w;
  logic [1:0]  sel_w;
  logic        valid_w;
  logic [7:0]  out_w;
  logic        out_valid_w;
  logic [3:0]  oh_w;

  logic [3:0]  in_c;
  logic [1:0]  sel_c;
  logic        valid_c;
  logic        out_c;
  logic        out_valid_c;
  logic [3:0]  oh_c;

  int total;
  int bad;

  mux41_d #(.DATA_W(1), .REG_OUT(1)) dut_n (
    .clk(clk), .rst_n(rst_n), .in(in_n), .sel(sel_n), .in_valid(valid_n),
    .out(out_n), .out_valid(out_valid_n), .sel_onehot(oh_n)
  );

  mux41_d #(.DATA_W(8), .REG_OUT(1)) dut_w (
    .clk(clk), .rst_n(rst_n), .in(in_w), .sel(sel_w), .in_valid(valid_w),
    .out(out_w), .out_valid(out_valid_w), .sel_onehot(oh_w)
  );

  mux41_d #(.DATA_W(1), .REG_OUT(0)) dut_c (
    .clk(clk), .rst_n(rst_n), .in(in_c), .sel(sel_c), .in_valid(valid_c),
    .out(out_c), .out_valid(out_valid_c), .sel_onehot(oh_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog got=timeout exp=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Drive the narrow registered instance between edges, then sample just after the capturing edge.
  task automatic applyStimulus(input logic [3:0] i, input logic [1:0] s, input logic v);
    @(negedge clk);
    in_n    = i;
    sel_n   = s;
    valid_n = v;
    @(posedge clk);
    #1;
  endtask

  task automatic checkNarrow(input string tag, input logic o, input logic v, input logic [3:0] oh);
    checkOutput({tag, "_out"}, {31'd0, out_n}, {31'd0, o});
    checkOutput({tag, "_vld"}, {31'd0, out_valid_n}, {31'd0, v});
    checkOutput({tag, "_oh"}, {28'd0, oh_n}, {28'd0, oh});
  endtask

  logic [3:0] sweep_in  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};
  logic [3:0] walk_in   [4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [1:0] sweep_sel [4] = '{2'd3, 2'd2, 2'd1, 2'd0};
  logic [3:0] sweep_oh  [4] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001};

  initial begin
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    in_n    = '0; sel_n = '0; valid_n = 1'b0;
    in_w    = '0; sel_w = '0; valid_w = 1'b0;
    in_c    = '0; sel_c = '0; valid_c = 1'b0;

    #3;
    checkNarrow("reset", 1'b0, 1'b0, 4'b0000);
    checkOutput("reset_w_out", {24'd0, out_w}, 32'd0);

    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 4; k++) begin
      applyStimulus(sweep_in[k], sweep_sel[k], 1'b1);
      checkNarrow($sformatf("sweep%0d", k), 1'b1, 1'b1, sweep_oh[k]);
    end

    for (int k = 0; k < 4; k++) begin
      applyStimulus(walk_in[k], sweep_sel[k], 1'b1);
      checkNarrow($sformatf("walk%0d", k), 1'b0, 1'b1, sweep_oh[k]);
    end

    applyStimulus(4'b0001, 2'd0, 1'b1);
    checkNarrow("hold_cap", 1'b1, 1'b1, 4'b0001);
    applyStimulus(4'b0000, 2'd0, 1'b0);
    checkNarrow("hold", 1'b1, 1'b0, 4'b0001);

    // Inputs wiggling between edges must not reach a registered output.
    applyStimulus(4'b0100, 2'd2, 1'b1);
    in_n  = 4'b1011;
    sel_n = 2'd1;
    #2;
    checkNarrow("between", 1'b1, 1'b1, 4'b0100);

    applyStimulus(4'b0010, 2'd1, 1'b1);
    checkNarrow("pre_rst", 1'b1, 1'b1, 4'b0010);
    #2;
    rst_n = 1'b0;
    #1;
    checkNarrow("async_rst", 1'b0, 1'b0, 4'b0000);
    @(posedge clk);
    #1;
    checkNarrow("rst_held", 1'b0, 1'b0, 4'b0000);

    @(negedge clk);
    rst_n   = 1'b1;
    in_n    = 4'b0100;
    sel_n   = 2'd2;
    valid_n = 1'b0;
    @(posedge clk);
    #1;
    checkNarrow("no_stale", 1'b0, 1'b0, 4'b0000);
    applyStimulus(4'b0100, 2'd2, 1'b1);
    checkNarrow("post_rst", 1'b1, 1'b1, 4'b0100);

    @(negedge clk);
    in_w = 32'hDDCCBBAA; sel_w = 2'd2; valid_w = 1'b1;
    #1;
    checkOutput("wide_latency", {24'd0, out_w}, 32'd0);
    @(posedge clk); #1;
    checkOutput("wide_cc", {24'd0, out_w}, 32'h0000_00CC);
    checkOutput("wide_oh", {28'd0, oh_w}, 32'h4);
    @(negedge clk); sel_w = 2'd0;
    @(posedge clk); #1;
    checkOutput("wide_aa", {24'd0, out_w}, 32'h0000_00AA);
    @(negedge clk); sel_w = 2'd3;
    @(posedge clk); #1;
    checkOutput("wide_dd", {24'd0, out_w}, 32'h0000_00DD);
    checkOutput("wide_vld", {31'd0, out_valid_w}, 32'd1);

    @(negedge clk);
    in_c = 4'b0100; sel_c = 2'd2; valid_c = 1'b1;
    #1;
    checkOutput("comb_out2", {31'd0, out_c}, 32'd1);
    checkOutput("comb_oh2", {28'd0, oh_c}, 32'h4);
    checkOutput("comb_vld1", {31'd0, out_valid_c}, 32'd1);
    sel_c = 2'd1;
    #1;
    checkOutput("comb_out1", {31'd0, out_c}, 32'd0);
    checkOutput("comb_oh1", {28'd0, oh_c}, 32'h2);
    valid_c = 1'b0;
    #1;
    checkOutput("comb_vld0", {31'd0, out_valid_c}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mux41_d.md
MUX41_D -- requirements
Module: mux41_d

Interface
REQ-001 Parameter DATA_W, default 1, is the width of each data lane in bits.
REQ-002 Parameter REG_OUT, default 1: 1 = registered output; 0 = combinational output.
REQ-003 Port clk, input, 1 bit, is the single clock; all state updates on its rising edge.
REQ-004 Port rst_n, input, 1 bit, is the asynchronous, active-low reset.
REQ-005 Port in, input, 4*DATA_W bits, carries four packed data lanes; lane k is in[k*DATA_W +: DATA_W].
REQ-006 Port sel, input, 2 bits, is the lane select (0..3).
REQ-007 Port in_valid, input, 1 bit, qualifies in/sel for capture.
REQ-008 Port out, output, DATA_W bits, is the selected lane.
REQ-009 Port out_valid, output, 1 bit, is high when out holds a result from a qualified input.
REQ-010 Port sel_onehot, output, 4 bits, is the one-hot decode of the select that produced out.

Function
- REQ-011 Selection: out SHALL equal lane[sel], i.e. in[sel*DATA_W +: DATA_W]; sel=0 selects the LSB lane, sel=3 the MSB lane.
- REQ-012 All four sel codes SHALL be valid; no out-of-range or default-to-X case SHALL exist.
- REQ-013 REG_OUT=1, in_valid=1 at edge N: out, sel_onehot and out_valid=1 SHALL appear after edge N (1-cycle latency).
- REQ-014 REG_OUT=1, in_valid=0 at an edge: out and sel_onehot SHALL hold their previous values; out_valid SHALL drop to 0.
- REQ-015 REG_OUT=1: back-to-back in_valid cycles SHALL give one result per cycle with no bubbles.
- REQ-016 REG_OUT=1: changes to in or sel between edges SHALL NOT affect out.
- REQ-017 REG_OUT=0: out SHALL track lane[sel] combinationally, sel_onehot SHALL track decode(sel), and out_valid SHALL equal in_valid.
- REQ-018 REG_OUT=0: the block SHALL hold no state; clk and rst_n are unused.
- REQ-019 sel_onehot SHALL have exactly one bit set whenever out_valid=1; bit k is set for sel=k.
- REQ-020 No output SHALL ever carry X when inputs are known.

Reset
- REQ-021 With REG_OUT=1, rst_n low SHALL immediately (asynchronously) force out to 0, out_valid to 0 and sel_onehot to 4'b0000.
- REQ-022 Deassertion of rst_n SHALL take effect at the next rising clk edge; the first capture is possible at the first edge with rst_n high.
- REQ-023 Reset asserted mid-stream SHALL discard any in-flight result; no stale out_valid SHALL follow reset release.

Structure
- REQ-024 Package mux41_pkg SHALL hold LANES=4, SEL_W=2 and a sel-to-one-hot decode function.
- REQ-025 The 2-to-4 one-hot decoder SHALL be the single sub-module, mux41_dec (sel in, onehot out, purely combinational).
- REQ-026 The mux datapath SHALL be an AND-OR of lanes gated by the one-hot, followed by the optional output register chosen by generate on REG_OUT.

Verification
- REQ-027 Reset: rst_n=0 mid-cycle with prior out_valid=1 -> out=0, out_valid=0, sel_onehot=0000 immediately, without waiting for a clock edge.
- REQ-028 Sweep, DATA_W=1, REG_OUT=1, one per cycle with in_valid=1:
  - in=4'b1000, sel=3 -> out=1 next cycle, sel_onehot=1000.
  - in=4'b0100, sel=2 -> out=1.
  - in=4'b0010, sel=1 -> out=1.
  - in=4'b0001, sel=0 -> out=1.
- REQ-029 Walking zero, in_valid=1: in=4'b0111, sel=3 -> out=0; in=4'b1011, sel=2 -> out=0; in=4'b1101, sel=1 -> out=0; in=4'b1110, sel=0 -> out=0.
- REQ-030 Hold: capture in=4'b0001, sel=0 (out=1), then in_valid=0 with in=4'b0000 -> out stays 1 and out_valid=0.
- REQ-031 Wide lanes: DATA_W=8, in=32'hDDCCBBAA, sel=2 -> out=8'hCC one cycle later.
- REQ-032 Combinational: REG_OUT=0, in=4'b0100, sel toggled 2->1 -> out goes 1->0 within the same cycle, out_valid=in_valid.
